// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the decode-stage register file.
package regfile_pkg;

    // Clear sequencer states: CLEAR zeroes the array after reset, READY serves traffic.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 64;

    // An address is usable only below DEPTH; matters when DEPTH is not a power of two.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, driving a zero write per cycle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int          ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] clr_ptr;

    // Advance the clear pointer; the last entry is written on the edge that enters READY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            if (clr_ptr == LAST_ADDR) begin
                state   <= READY;
                clr_ptr <= '0;
            end else begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_bypass.sv
// 2-read/1-write register file with registered reads, optional write-to-read
// forwarding, optional hardwired zero register and a post-reset clear sequence.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rs_en,
    input  logic              rt_en,
    output logic [WIDTH-1:0]  rsdata,
    output logic [WIDTH-1:0]  rtdata,
    output logic              busy
);

    logic [WIDTH-1:0]  block [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [WIDTH-1:0]  rs_next;
    logic [WIDTH-1:0]  rt_next;

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A writeback is accepted only once the clear is done, for an in-range,
    // non-hardwired register; forwarding follows the same qualification.
    assign wr_ok = !busy && write && addr_valid(32'(rd), DEPTH)
                   && !(ZERO_REG && (rd == '0));

    // Array write mux: the clear sequence owns the write port while it runs.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            block[clr_addr] <= '0;
        end else if (wr_ok) begin
            block[rd] <= wdata;
        end
    end

    // Next read data for both ports: out-of-range/zero-reg -> 0, then forward, then array.
    always_comb begin
        rs_next = '0;
        rt_next = '0;
        if (addr_valid(32'(rs), DEPTH) && !(ZERO_REG && (rs == '0))) begin
            if (BYPASS && wr_ok && (rd == rs)) rs_next = wdata;
            else                               rs_next = block[rs];
        end
        if (addr_valid(32'(rt), DEPTH) && !(ZERO_REG && (rt == '0))) begin
            if (BYPASS && wr_ok && (rd == rt)) rt_next = wdata;
            else                               rt_next = block[rt];
        end
    end

    // Registered read ports; they hold when disabled and stay at 0 during the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsdata <= '0;
            rtdata <= '0;
        end else if (!busy) begin
            if (rs_en) rsdata <= rs_next;
            if (rt_en) rtdata <= rt_next;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: four configurations share one stimulus stream and
// are checked every cycle against a spec-level model, plus literal spot checks.
module tb_regfile_bypass;

    localparam int NI = 4;
    // 0: default, 1: no bypass, 2: zero register, 3: depth 40
    int cfg_depth [NI] = '{64, 64, 64, 40};
    bit cfg_byp   [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit cfg_zero  [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [5:0]  rd = '0, rs = '0, rt = '0;
    logic [31:0] wdata = '0;
    logic        rs_en = 1'b0, rt_en = 1'b0;
    logic [31:0] rsd [NI];
    logic [31:0] rtd [NI];
    logic        bsy [NI];

    int n_checks = 0;
    int n_fail = 0;
    bit running = 1'b0;

    logic [31:0] mem [NI][64];
    logic [31:0] exp_rs [NI];
    logic [31:0] exp_rt [NI];
    int          clr_left [NI];

    always #5 clk = ~clk;

    regfile_bypass #(.WIDTH(32), .DEPTH(64), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut0 (
        .clock(clk), .reset(reset), .write(write), .rd(rd), .wdata(wdata), .rs(rs), .rt(rt),
        .rs_en(rs_en), .rt_en(rt_en), .rsdata(rsd[0]), .rtdata(rtd[0]), .busy(bsy[0]));
    regfile_bypass #(.WIDTH(32), .DEPTH(64), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut1 (
        .clock(clk), .reset(reset), .write(write), .rd(rd), .wdata(wdata), .rs(rs), .rt(rt),
        .rs_en(rs_en), .rt_en(rt_en), .rsdata(rsd[1]), .rtdata(rtd[1]), .busy(bsy[1]));
    regfile_bypass #(.WIDTH(32), .DEPTH(64), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut2 (
        .clock(clk), .reset(reset), .write(write), .rd(rd), .wdata(wdata), .rs(rs), .rt(rt),
        .rs_en(rs_en), .rt_en(rt_en), .rsdata(rsd[2]), .rtdata(rtd[2]), .busy(bsy[2]));
    regfile_bypass #(.WIDTH(32), .DEPTH(40), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut3 (
        .clock(clk), .reset(reset), .write(write), .rd(rd), .wdata(wdata), .rs(rs), .rt(rt),
        .rs_en(rs_en), .rt_en(rt_en), .rsdata(rsd[3]), .rtdata(rtd[3]), .busy(bsy[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // What a read of register a returns on an edge whose write is (acc ? accepted : not).
    function automatic logic [31:0] model_read(input int k, input logic [5:0] a, input bit acc);
        if (int'(a) >= cfg_depth[k]) return 32'h0;
        if (cfg_zero[k] && a == 6'd0) return 32'h0;
        if (cfg_byp[k] && acc && a == rd) return wdata;
        return mem[k][a];
    endfunction

    // Behavioural model: after reset the file reads as all-zero and ignores traffic for DEPTH edges.
    always @(posedge clk) begin
        bit acc;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                clr_left[k] = cfg_depth[k];
                exp_rs[k] = 32'h0;
                exp_rt[k] = 32'h0;
                for (int a = 0; a < 64; a++) mem[k][a] = 32'h0;
            end else if (clr_left[k] > 0) begin
                clr_left[k]--;
            end else begin
                acc = write && (int'(rd) < cfg_depth[k]) && !(cfg_zero[k] && rd == 6'd0);
                if (rs_en) exp_rs[k] = model_read(k, rs, acc);
                if (rt_en) exp_rt[k] = model_read(k, rt, acc);
                if (acc) mem[k][rd] = wdata;
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (running) begin
            for (int k = 0; k < NI; k++) begin
                if (reset) begin
                    chk($sformatf("reset busy[%0d]", k), 32'(bsy[k]), 32'd1);
                    chk($sformatf("reset rsdata[%0d]", k), rsd[k], 32'h0);
                    chk($sformatf("reset rtdata[%0d]", k), rtd[k], 32'h0);
                end else begin
                    chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(clr_left[k] > 0));
                    chk($sformatf("rsdata[%0d]", k), rsd[k], exp_rs[k]);
                    chk($sformatf("rtdata[%0d]", k), rtd[k], exp_rt[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c, d0, d3;
        tick();
        running = 1'b1;
        tick();
        reset = 1'b0;

        // Interrupt the clear at clr_ptr = 20 and check it restarts from scratch.
        repeat (20) tick();
        chk("busy mid-clear", 32'(bsy[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        write = 1'b1; rd = 6'd3; wdata = 32'd9;
        c = 0; d0 = -1; d3 = -1;
        while (c < 100 && (bsy[0] || bsy[3])) begin
            tick();
            c++;
            if (!bsy[0] && d0 < 0) d0 = c;
            if (!bsy[3] && d3 < 0) d3 = c;
        end
        write = 1'b0;
        chk("busy length depth64", 32'(d0), 32'd64);
        chk("busy length depth40", 32'(d3), 32'd40);

        // Sweep every address on both ports; all must read 0 except reg 3 of dut3.
        rs_en = 1'b1; rt_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            rs = 6'(a); rt = 6'(63 - a);
            tick();
        end
        rs = 6'd3; rt_en = 1'b0;
        tick();
        chk("write during clear dropped", rsd[2], 32'h0);
        chk("write during clear dropped d0", rsd[0], 32'h0);

        // Basic write then read.
        rs_en = 1'b0; rt_en = 1'b0;
        write = 1'b1; rd = 6'd5; wdata = 32'hDEADBEEF;
        tick();
        write = 1'b0; rs = 6'd5; rt = 6'd6; rs_en = 1'b1; rt_en = 1'b1;
        tick();
        chk("basic read rs=5", rsd[0], 32'hDEADBEEF);
        chk("basic read rt=6", rtd[0], 32'h0);

        // Same-edge write and read of reg 7 on both ports.
        write = 1'b1; rd = 6'd7; wdata = 32'h12345678; rs = 6'd7; rt = 6'd7;
        tick();
        chk("bypass rs", rsd[0], 32'h12345678);
        chk("bypass rt", rtd[0], 32'h12345678);
        chk("no-bypass rs old", rsd[1], 32'h0);
        chk("no-bypass rt old", rtd[1], 32'h0);
        write = 1'b0;
        tick();
        chk("no-bypass rs new", rsd[1], 32'h12345678);

        // Disabled port holds while other registers change.
        rs_en = 1'b0; rt_en = 1'b0;
        write = 1'b1; rd = 6'd10; wdata = 32'hA5A5A5A5;
        tick();
        write = 1'b0; rs = 6'd10; rs_en = 1'b1;
        tick();
        rs_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs = 6'(11 + i); write = 1'b1; rd = 6'(11 + i); wdata = $urandom;
            tick();
        end
        write = 1'b0;
        chk("hold rs d0", rsd[0], 32'hA5A5A5A5);
        chk("hold rs d1", rsd[1], 32'hA5A5A5A5);

        // Writes to register 0.
        write = 1'b1; rd = 6'd0; wdata = 32'hFFFFFFFF; rs = 6'd0; rs_en = 1'b1;
        tick();
        chk("zero reg no forward", rsd[2], 32'h0);
        chk("reg0 forward normal", rsd[0], 32'hFFFFFFFF);
        write = 1'b0;
        tick();
        chk("zero reg later read", rsd[2], 32'h0);
        chk("reg0 stored normal", rsd[1], 32'hFFFFFFFF);

        // Address 45: beyond DEPTH=40, valid for DEPTH=64.
        write = 1'b1; rd = 6'd45; wdata = 32'hCAFEF00D; rs = 6'd45; rt = 6'd45; rt_en = 1'b1;
        tick();
        chk("oor rs no forward", rsd[3], 32'h0);
        chk("oor rt no forward", rtd[3], 32'h0);
        chk("in-range 45 forward", rsd[0], 32'hCAFEF00D);
        write = 1'b0;
        tick();
        chk("oor rs dropped", rsd[3], 32'h0);
        chk("in-range 45 stored", rsd[1], 32'hCAFEF00D);

        // Mixed traffic, checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            write = 1'($urandom); rd = 6'($urandom); wdata = $urandom;
            rs = 6'($urandom); rt = (i % 5 == 0) ? rs : 6'($urandom);
            rs_en = 1'($urandom); rt_en = 1'($urandom);
            tick();
        end
        write = 1'b0;
        tick();
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised successor of the CPU's 2-read/1-write register file.
- Width, depth and zero-register mode are configurable; reads stay registered, with 1-cycle latency.
- Adds write-to-read bypass, per-port read enables, and a post-reset clear sequencer that zeroes the array.
- Sits in the decode stage: rs/rt come from the instruction, rd/write/wdata come from writeback.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 64, number of registers; must be ≥2.
- ADDR_W, $clog2(DEPTH), register address width; derived, not to be overridden.
- BYPASS, 1, 1 = same-edge write data forwarded to a matching read; 0 = read returns old contents.
- ZERO_REG, 0, 1 = register 0 is hardwired to zero.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- write  in  1  write enable for rd
- rd  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- rs  in  ADDR_W  read address, port A
- rt  in  ADDR_W  read address, port B
- rs_en  in  1  port A read enable
- rt_en  in  1  port B read enable
- rsdata  out  WIDTH  registered read data, port A
- rtdata  out  WIDTH  registered read data, port B
- busy  out  1  high while the clear sequence runs

Behaviour:
- Reset (async, active-high):
  - rsdata = 0, rtdata = 0, busy = 1, state = CLEAR, clr_ptr = 0.
  - Array contents are not reset asynchronously.
- FSM states CLEAR and READY:
  - CLEAR, each posedge after reset deasserts: block[clr_ptr] <= 0, clr_ptr++.
  - When clr_ptr == DEPTH-1, that entry is written and state -> READY on the same edge.
  - busy is high for exactly DEPTH posedges after reset release, then low.
  - READY persists until the next reset.
- In CLEAR:
  - write is ignored.
  - rsdata/rtdata hold 0 regardless of rs_en/rt_en.
- Reset mid-clear: restarts from clr_ptr = 0 with full DEPTH cycles.
- READY, each posedge:
  - Write: if write and rd is valid (and not 0 when ZERO_REG=1), block[rd] <= wdata.
  - Port A, if rs_en:
    - rsdata <= wdata when BYPASS=1 and write and rd==rs and the write is accepted;
    - otherwise rsdata <= block[rs] (pre-edge contents).
  - If rs_en=0, rsdata holds.
  - Port B: same rules with rt/rt_en/rtdata.
  - Read latency is 1 cycle: the address presented before edge N gives data valid after edge N.
- BYPASS=0 gives read-before-write: same-edge read of rd returns the old value; the new value is visible from the next read.
- ZERO_REG=1: reads of address 0 return 0; writes to 0 are dropped and never forwarded.
- Out-of-range address (DEPTH not a power of two, address ≥ DEPTH):
  - read returns 0;
  - write is dropped, with no bypass.
- Both ports may read the same address in the same cycle; both get identical data.
- Width rule: wdata is stored as-is, with no extension or truncation.

Decomposition:
- Package regfile_pkg:
  - state enum (CLEAR, READY);
  - default WIDTH/DEPTH constants;
  - function addr_valid(addr, depth).
- Sub-module regfile_clear_fsm:
  - owns state, clr_ptr and busy;
  - outputs clr_we/clr_addr to the array write mux.
- Top level holds the array, write mux (clear has priority) and the two bypassed read ports.

Test Plan:
- Clear sequence: pulse reset 2 cycles, release → busy high exactly 64 posedges then 0; afterwards reading every address gives 0; rsdata/rtdata = 0 throughout.
- Basic write/read: write rd=5, wdata=0xDEADBEEF; next cycle rs=5, rs_en=1 → rsdata=0xDEADBEEF one edge later; rt=6 → 0.
- Bypass: same edge write rd=7, wdata=0x12345678, rs=7, rt=7, both enables on:
  - BYPASS=1 → both outputs 0x12345678 after that edge;
  - BYPASS=0 → both show the old value 0, then 0x12345678 on the next read.
- Enables/hold: rsdata=0xA5A5A5A5, drop rs_en, change rs and write other registers for 3 cycles → rsdata stays 0xA5A5A5A5.
- ZERO_REG=1: write rd=0, wdata=0xFFFFFFFF with rs=0 on the same edge → rsdata=0; later read of 0 → 0. Write during busy (rd=3, wdata=9) → after clear, reg 3 reads 0.
- Mid-clear reset plus odd depth:
  - assert reset at clr_ptr=20 → busy restarts, stays high 64 more cycles;
  - DEPTH=40: read rs=45 → 0; write rd=45 is dropped and not forwarded.
